accel_run_ctrl: RTL and testbench

//  Run sequencer for the TOP accelerator core. Turns a user go request into a one-cycle acc_start,

---
 rtl/accel_pkg.sv | 24 ++
 rtl/accel_wdog.sv | 34 +++
 rtl/accel_run_ctrl.sv | 156 +++++++++++++++
 tb/tb_accel_run_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator run sequencer: state encoding, LED layout, defaults.
package accel_pkg;

  localparam int RES_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam int LED_BUSY = 0;
  localparam int LED_OK   = 1;
  localparam int LED_ERR  = 2;
  localparam int LED_RUN0 = 3;

  function automatic logic is_busy(input state_e s);
    return (s == ST_LAUNCH) || (s == ST_WAIT) || (s == ST_CAPTURE) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/accel_wdog.sv
// Up-counter with clear/enable and a terminal flag against a loadable terminal value.
module accel_wdog #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/accel_run_ctrl.sv
// Run sequencer for the TOP accelerator core: go edge -> start pulse, done/watchdog wait,
// result capture, optional auto-repeat, status LEDs.
module accel_run_ctrl
  import accel_pkg::*;
#(
  parameter int RES_W       = RES_W_DEF,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11,
  parameter int AUTO_GAP    = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             auto_mode,
  input  logic             abort,
  input  logic             clr_err,
  output logic             acc_start,
  input  logic             acc_done,
  input  logic [RES_W-1:0] acc_result,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] run_count,
  output logic [3:0]       led,
  output state_e           dbg_state
);

  // Core handshake: acc_start is a single-cycle strobe; acc_done is a single-cycle strobe
  // honoured only in WAIT, with acc_result qualified by it. No backpressure either way.
  state_e           state_q, state_d;
  logic             go_q;
  logic [RES_W-1:0] result_q, result_d;
  logic             rv_q, rv_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [3:0]       led_q, led_d;
  logic             wd_clr, wd_en, wd_tc;
  logic [TO_W-1:0]  wd_term;

  // One counter serves both phases; the terminal value follows the current state.
  assign wd_term = (state_q == ST_WAIT) ? TO_W'(TIMEOUT_CYC - 1) : TO_W'(AUTO_GAP - 1);

  accel_wdog #(.W(TO_W)) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_clr),
    .en   (wd_en),
    .term (wd_term),
    .tc   (wd_tc)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rv_d     = 1'b0;
    count_d  = count_q;
    ok_d     = ok_q;
    err_d    = err_q;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      ST_IDLE: if (go && !go_q) state_d = ST_LAUNCH;
      ST_LAUNCH: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        if (acc_done) begin
          state_d  = ST_CAPTURE;
          result_d = acc_result;
          rv_d     = 1'b1;
          count_d  = count_q + CNT_W'(1);
          ok_d     = 1'b1;
        end else if (wd_tc) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
          ok_d    = 1'b0;
        end
      end
      ST_CAPTURE: begin
        wd_clr  = 1'b1;
        state_d = auto_mode ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        wd_en = 1'b1;
        if (!auto_mode) state_d = ST_IDLE;
        else if (wd_tc) state_d = ST_LAUNCH;
      end
      ST_FAULT: begin
        if (clr_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides any capture or timeout decided above in the same cycle.
    if (abort && is_busy(state_q)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rv_d     = 1'b0;
      count_d  = count_q;
      ok_d     = ok_q;
      err_d    = err_q;
    end
    start_d         = (state_d == ST_LAUNCH);
    busy_d          = is_busy(state_d);
    led_d           = '0;
    led_d[LED_BUSY] = busy_d;
    led_d[LED_OK]   = ok_d;
    led_d[LED_ERR]  = err_d;
    led_d[LED_RUN0] = count_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      go_q     <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
      count_q  <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= go;
      result_q <= result_d;
      rv_q     <= rv_d;
      count_q  <= count_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      led_q    <= led_d;
    end
  end

  assign acc_start    = start_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;
  assign run_count    = count_q;
  assign led          = led_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_accel_run_ctrl.sv
// Randomized self-checking bench for accel_run_ctrl against a transaction-level model.
module tb_accel_run_ctrl;
  import accel_pkg::*;

  localparam int RES_W   = 10;
  localparam int TIMEOUT = 8;
  localparam int GAP     = 4;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             go, auto_mode, abort, clr_err, acc_done;
  logic [RES_W-1:0] acc_result;
  logic             acc_start, result_valid, busy, err_timeout;
  logic [RES_W-1:0] result;
  logic [CNT_W-1:0] run_count;
  logic [3:0]       led;
  state_e           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_starts = 0;
  bit prev_start = 1'b0;

  // Reference model: outcome of completed transactions only.
  int               exp_count = 0;
  logic [RES_W-1:0] exp_result = '0;
  bit               exp_ok = 1'b0;
  bit               exp_err = 1'b0;
  logic [RES_W-1:0] exp_q[$];

  accel_run_ctrl #(
    .RES_W(RES_W), .TIMEOUT_CYC(TIMEOUT), .TO_W(11), .AUTO_GAP(GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .auto_mode(auto_mode), .abort(abort), .clr_err(clr_err),
    .acc_start(acc_start), .acc_done(acc_done), .acc_result(acc_result), .result(result),
    .result_valid(result_valid), .busy(busy), .err_timeout(err_timeout),
    .run_count(run_count), .led(led), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_led(input bit b);
    logic [CNT_W-1:0] c;
    c = CNT_W'(exp_count);
    return {c[0], exp_err, exp_ok, b};
  endfunction

  // Monitor: start pulses are single-cycle, every result_valid matches an expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_start) begin
        n_starts++;
        check("start_1cyc", prev_start, 0);
      end
      if (result_valid) begin
        if (exp_q.size() == 0) check("rv_unexpected", 1, 0);
        else check("rv_data", result, exp_q.pop_front());
      end
    end
    prev_start = acc_start;
  end

  task automatic do_run(input int lat, input logic [RES_W-1:0] val, input bit keep_go);
    int s0;
    s0 = n_starts;
    go = 1'b1;
    step();
    check("launch_start", acc_start, 1);
    check("launch_busy", busy, 1);
    if (!keep_go) go = 1'b0;
    step();
    for (int k = 1; k < lat; k++) begin
      check("wait_busy", busy, 1);
      check("wait_nostart", acc_start, 0);
      step();
    end
    acc_done   = 1'b1;
    acc_result = val;
    exp_q.push_back(val);
    step();
    acc_done   = 1'b0;
    acc_result = RES_W'($urandom);
    exp_count  = (exp_count + 1) % (1 << CNT_W);
    exp_result = val;
    exp_ok     = 1'b1;
    check("cap_rv", result_valid, 1);
    check("cap_result", result, val);
    check("cap_count", run_count, exp_count);
    check("cap_led", led, exp_led(1'b1));
    step();
    check("idle_rv", result_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_led", led, exp_led(1'b0));
    check("run_starts", n_starts - s0, 1);
  endtask

  initial begin
    int s, last, lat, n;
    logic [RES_W-1:0] v;
    rst = 1'b1; go = 0; auto_mode = 0; abort = 0; clr_err = 0; acc_done = 0; acc_result = '0;
    repeat (3) step();
    check("rst_start", acc_start, 0);
    check("rst_rv", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_count", run_count, 0);
    check("rst_led", led, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    step();

    // Directed single run, then a spurious done in IDLE.
    do_run(5, 10'h2A5, 1'b0);
    check("t1_led", led, 4'b1010);
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    check("spur_state", dbg_state, ST_IDLE);
    step();
    check("spur_rv", result_valid, 0);

    // Random runs including the done-on-last-watchdog-cycle boundary.
    for (int i = 0; i < 8; i++) begin
      do_run($urandom_range(1, TIMEOUT), RES_W'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end
    do_run(TIMEOUT, RES_W'($urandom), 1'b0);

    // go held high for 50 cycles yields one run.
    s = n_starts;
    lat = $urandom_range(1, 6);
    do_run(lat, RES_W'($urandom), 1'b1);
    repeat (50 - lat - 3) step();
    check("held_go_starts", n_starts - s, 1);
    check("held_go_busy", busy, 0);
    go = 1'b0;
    step();

    // Watchdog timeout, fault lock-out, clear.
    go = 1'b1;
    step();
    check("to_launch", acc_start, 1);
    go = 1'b0;
    step();
    for (int k = 1; k <= TIMEOUT; k++) begin
      check("to_wait_busy", busy, 1);
      check("to_wait_err", err_timeout, 0);
      step();
    end
    exp_err = 1'b1;
    exp_ok  = 1'b0;
    check("to_err", err_timeout, 1);
    check("to_busy", busy, 0);
    check("to_led", led, exp_led(1'b0));
    s = n_starts;
    go = 1'b1;
    abort = 1'b1;
    step();
    go = 1'b0;
    abort = 1'b0;
    repeat (3) step();
    check("fault_go_ignored", n_starts - s, 0);
    check("fault_err_held", err_timeout, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    exp_err = 1'b0;
    check("clr_err", err_timeout, 0);
    check("clr_state", dbg_state, ST_IDLE);
    check("clr_led", led, exp_led(1'b0));
    do_run($urandom_range(1, 4), RES_W'($urandom), 1'b0);

    // Auto-repeat with random core latency, then drop auto_mode inside GAP.
    auto_mode = 1'b1;
    go = 1'b1;
    step();
    check("auto_launch", acc_start, 1);
    go = 1'b0;
    last = cyc;
    for (int r = 0; r < 3; r++) begin
      lat = $urandom_range(1, 4);
      v = RES_W'($urandom);
      step();
      for (int k = 1; k < lat; k++) step();
      acc_done = 1'b1;
      acc_result = v;
      exp_q.push_back(v);
      step();
      acc_done = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      exp_result = v;
      exp_ok = 1'b1;
      check("auto_rv", result_valid, 1);
      check("auto_count", run_count, exp_count);
      if (r < 2) begin
        n = 0;
        while (!acc_start && n < 20) begin
          step();
          n++;
        end
        check("auto_restart", acc_start, 1);
        check("auto_spacing", cyc - last, lat + 2 + GAP);
        last = cyc;
      end else begin
        step();
        step();
        check("gap_busy", busy, 1);
        auto_mode = 1'b0;
        step();
        check("gap_exit_state", dbg_state, ST_IDLE);
        check("gap_exit_busy", busy, 0);
        s = n_starts;
        repeat (20) step();
        check("gap_no_restart", n_starts - s, 0);
      end
    end

    // Abort coincident with done, and abort in LAUNCH.
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    acc_done = 1'b1;
    acc_result = ~exp_result;
    abort = 1'b1;
    step();
    acc_done = 1'b0;
    abort = 1'b0;
    check("abort_rv", result_valid, 0);
    check("abort_result", result, exp_result);
    check("abort_count", run_count, exp_count);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_busy", busy, 0);
    go = 1'b1;
    step();
    go = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_launch_state", dbg_state, ST_IDLE);
    check("abort_launch_count", run_count, exp_count);

    // Reset in WAIT, then 256 runs to wrap the counter.
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("mid_rst_start", acc_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_count", run_count, 0);
    check("mid_rst_led", led, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    step();
    rst = 1'b0;
    exp_count = 0; exp_result = '0; exp_ok = 1'b0; exp_err = 1'b0;
    exp_q.delete();
    step();
    for (int i = 0; i < 256; i++) do_run($urandom_range(1, 2), RES_W'($urandom), 1'b0);
    check("wrap_count", run_count, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
